// File: rtl/approx_mult_err_monitor.sv
// Windowed error-statistics monitor for unsigned 8x8 approximate multipliers.
// Optional squared-error accumulator enabled by defining ERR_SQ_EN.
module approx_mult_err_monitor #(
    parameter int WIN_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              x,
    input  logic [7:0]              y,
    input  logic [15:0]             z_approx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16+WIN_LOG2-1:0]  sum_abs,
    output logic [17+WIN_LOG2-1:0]  sum_err,
    output logic [15:0]             max_abs,
    output logic [WIN_LOG2:0]       nz_cnt
`ifdef ERR_SQ_EN
    ,
    output logic [32+WIN_LOG2-1:0]  sum_sq
`endif
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIN_LOG2:0] LAST_CNT = (WIN_LOG2+1)'((1 << WIN_LOG2) - 1);

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [WIN_LOG2:0]       cnt_r;
    logic                    s1_valid_r;
    logic [15:0]             exact_r;
    logic [15:0]             z_r;
    logic                    accept_s;
    logic                    restart_s;
    logic [16:0]             diff_s;
    logic [15:0]             abs_s;
    logic                    nz_s;
    logic [16+WIN_LOG2-1:0]  sum_abs_r;
    logic [17+WIN_LOG2-1:0]  sum_err_r;
    logic [15:0]             max_abs_r;
    logic [WIN_LOG2:0]       nz_cnt_r;

    // Acceptance is suppressed by clr so a sample offered alongside it is dropped.
    assign accept_s  = in_valid && in_ready_r && !clr;
    assign restart_s = clr || ((state_r == HOLD) && out_ready);

    assign diff_s = {1'b0, exact_r} - {1'b0, z_r};
    assign abs_s  = (exact_r >= z_r) ? (exact_r - z_r) : (z_r - exact_r);
    assign nz_s   = (exact_r != z_r);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; clr forces ACCUM from any state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACCUM: begin
                if (accept_s && (cnt_r == LAST_CNT)) state_next_s = DRAIN;
                else                                  state_next_s = ACCUM;
            end
            DRAIN: begin
                if (!s1_valid_r) state_next_s = HOLD;
                else             state_next_s = DRAIN;
            end
            HOLD: begin
                if (out_ready) state_next_s = ACCUM;
                else           state_next_s = HOLD;
            end
            default: state_next_s = ACCUM;
        endcase
        if (clr) state_next_s = ACCUM;
        else     state_next_s = state_next_s;
    end

    // Handshake flags registered from the next state so they align with state_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ACCUM);
            out_valid_r <= (state_next_s == HOLD);
        end
    end

    // Window sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (restart_s) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + {{WIN_LOG2{1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Stage 1: exact product and captured approximation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            exact_r    <= 16'd0;
            z_r        <= 16'd0;
        end else if (restart_s) begin
            s1_valid_r <= 1'b0;
            exact_r    <= 16'd0;
            z_r        <= 16'd0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                exact_r <= 16'(x) * 16'(y);
                z_r     <= z_approx;
            end else begin
                exact_r <= exact_r;
                z_r     <= z_r;
            end
        end
    end

    // Stage 2: statistics accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_abs_r <= '0;
            sum_err_r <= '0;
            max_abs_r <= 16'd0;
            nz_cnt_r  <= '0;
        end else if (restart_s) begin
            sum_abs_r <= '0;
            sum_err_r <= '0;
            max_abs_r <= 16'd0;
            nz_cnt_r  <= '0;
        end else if (s1_valid_r) begin
            sum_abs_r <= sum_abs_r + {{WIN_LOG2{1'b0}}, abs_s};
            sum_err_r <= sum_err_r + {{WIN_LOG2{diff_s[16]}}, diff_s};
            max_abs_r <= (abs_s > max_abs_r) ? abs_s : max_abs_r;
            nz_cnt_r  <= nz_cnt_r + {{WIN_LOG2{1'b0}}, nz_s};
        end else begin
            sum_abs_r <= sum_abs_r;
            sum_err_r <= sum_err_r;
            max_abs_r <= max_abs_r;
            nz_cnt_r  <= nz_cnt_r;
        end
    end

`ifdef ERR_SQ_EN
    logic [31:0]            sq_s;
    logic [32+WIN_LOG2-1:0] sum_sq_r;

    // |err|^2 equals err^2 and keeps the multiplier unsigned
    assign sq_s = 32'(abs_s) * 32'(abs_s);

    // Squared-error accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_sq_r <= '0;
        end else if (restart_s) begin
            sum_sq_r <= '0;
        end else if (s1_valid_r) begin
            sum_sq_r <= sum_sq_r + {{WIN_LOG2{1'b0}}, sq_s};
        end else begin
            sum_sq_r <= sum_sq_r;
        end
    end

    assign sum_sq = sum_sq_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum_abs   = sum_abs_r;
    assign sum_err   = sum_err_r;
    assign max_abs   = max_abs_r;
    assign nz_cnt    = nz_cnt_r;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Self-checking bench: WIN_LOG2=2 directed/random windows plus WIN_LOG2=10 full-rate random windows.
module tb_approx_mult_err_monitor;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
    } samp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        clr_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b1;
    logic        in_ready_a, out_valid_a;
    logic [7:0]  x_a = 8'd0, y_a = 8'd0;
    logic [15:0] z_a = 16'd0;
    logic [17:0] sum_abs_a;
    logic [18:0] sum_err_a;
    logic [15:0] max_abs_a;
    logic [2:0]  nz_cnt_a;

    logic        clr_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
    logic        in_ready_b, out_valid_b;
    logic [7:0]  x_b = 8'd0, y_b = 8'd0;
    logic [15:0] z_b = 16'd0;
    logic [25:0] sum_abs_b;
    logic [26:0] sum_err_b;
    logic [15:0] max_abs_b;
    logic [10:0] nz_cnt_b;
`ifdef ERR_SQ_EN
    logic [33:0] sum_sq_a;
    logic [41:0] sum_sq_b;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    samp_t mq[$];

    always #5 clk = ~clk;

    approx_mult_err_monitor #(.WIN_LOG2(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .x(x_a), .y(y_a), .z_approx(z_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .sum_abs(sum_abs_a), .sum_err(sum_err_a), .max_abs(max_abs_a), .nz_cnt(nz_cnt_a)
`ifdef ERR_SQ_EN
        , .sum_sq(sum_sq_a)
`endif
    );

    approx_mult_err_monitor #(.WIN_LOG2(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .x(x_b), .y(y_b), .z_approx(z_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .sum_abs(sum_abs_b), .sum_err(sum_err_b), .max_abs(max_abs_b), .nz_cnt(nz_cnt_b)
`ifdef ERR_SQ_EN
        , .sum_sq(sum_sq_b)
`endif
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference statistics over every sample queued since the last call
    task automatic calc(output longint e_abs, output longint e_err, output longint e_max,
                        output longint e_nz, output longint e_sq);
        longint e, a;
        e_abs = 0; e_err = 0; e_max = 0; e_nz = 0; e_sq = 0;
        foreach (mq[i]) begin
            e = longint'(mq[i].x) * longint'(mq[i].y) - longint'(mq[i].z);
            a = (e < 0) ? -e : e;
            e_abs += a;
            e_err += e;
            if (a > e_max) e_max = a;
            if (e != 0) e_nz++;
            e_sq += e * e;
        end
        mq.delete();
    endtask

    task automatic send_a(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] zv);
        samp_t s;
        x_a = xv; y_a = yv; z_a = zv; in_valid_a = 1'b1;
        chk("in_ready_a_before_accept", in_ready_a, 1);
        @(posedge clk); #1;
        s.x = xv; s.y = yv; s.z = zv;
        mq.push_back(s);
        in_valid_a = 1'b0;
    endtask

    task automatic send_rand_a(input int n);
        logic [7:0]  xv, yv;
        logic [15:0] zv;
        for (int i = 0; i < n; i++) begin
            xv = 8'($urandom);
            yv = 8'($urandom);
            zv = ($urandom_range(0, 2) == 0) ? 16'(xv) * 16'(yv) : 16'($urandom);
            send_a(xv, yv, zv);
        end
    endtask

    // Waits for the result after the last accept, compares it, and completes the handshake
    task automatic finish_a(input string tag);
        longint e_abs, e_err, e_max, e_nz, e_sq;
        int lat;
        lat = 0;
        while (!out_valid_a && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_valid_latency"}, lat, 2);
        calc(e_abs, e_err, e_max, e_nz, e_sq);
        chk({tag, "_sum_abs"}, sum_abs_a, e_abs);
        chk({tag, "_sum_err"}, $signed(sum_err_a), e_err);
        chk({tag, "_max_abs"}, max_abs_a, e_max);
        chk({tag, "_nz_cnt"}, nz_cnt_a, e_nz);
`ifdef ERR_SQ_EN
        chk({tag, "_sum_sq"}, sum_sq_a, e_sq);
`endif
        chk({tag, "_in_ready_hold"}, in_ready_a, 0);
        if (out_ready_a) begin
            @(posedge clk); #1;
            chk({tag, "_valid_pulse_end"}, out_valid_a, 0);
            chk({tag, "_in_ready_back"}, in_ready_a, 1);
            chk({tag, "_cleared"}, sum_abs_a, 0);
        end
    endtask

    initial begin
        longint e_abs, e_err, e_max, e_nz, e_sq;
        longint ex_abs[3], ex_err[3], ex_max[3], ex_nz[3], ex_sq[3];
        int first_acc[3];
        logic [17:0] snap_abs;
        logic [18:0] snap_err;
        logic [2:0]  snap_nz;
        int cyc, nacc, widx, outs;
        logic acc;
        samp_t s;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_sum_abs", sum_abs_a, 0);
        chk("rst_sum_err", sum_err_a, 0);
        chk("rst_nz_cnt", nz_cnt_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact input, pulse must not repeat
        for (int i = 0; i < 4; i++) send_a(8'd255, 8'd255, 16'd65025);
        finish_a("exact");
        repeat (2) @(posedge clk);
        #1;
        chk("exact_no_second_pulse", out_valid_a, 0);

        // Constant under-estimate
        for (int i = 0; i < 4; i++) send_a(8'd200, 8'd100, 16'd19900);
        chk("under_partial_nonzero", (sum_abs_a != 0), 1);
        finish_a("under");

        // Mixed signs: +5, -3, 0, -65535
        send_a(8'd10, 8'd10, 16'd95);
        send_a(8'd10, 8'd10, 16'd103);
        send_a(8'd3, 8'd3, 16'd9);
        send_a(8'd0, 8'd0, 16'd65535);
        finish_a("mixed");

        // Backpressure: result held for 5 cycles while in_valid is ignored
        out_ready_a = 1'b0;
        send_rand_a(4);
        finish_a("bp");
        snap_abs = sum_abs_a; snap_err = sum_err_a; snap_nz = nz_cnt_a;
        in_valid_a = 1'b1; x_a = 8'd17; y_a = 8'd33; z_a = 16'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_held", out_valid_a, 1);
            chk("bp_in_ready_low", in_ready_a, 0);
            chk("bp_sum_abs_stable", sum_abs_a, snap_abs);
            chk("bp_sum_err_stable", sum_err_a, snap_err);
            chk("bp_nz_stable", nz_cnt_a, snap_nz);
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid_a, 0);
        chk("bp_release_in_ready", in_ready_a, 1);
        chk("bp_release_cleared", nz_cnt_a, 0);
        send_rand_a(4);
        finish_a("bp_next");

        // clr after 2 samples; a sample offered with clr is discarded
        send_a(8'd200, 8'd100, 16'd19900);
        send_a(8'd200, 8'd100, 16'd19900);
        chk("clr_pre_sum_abs", sum_abs_a, 100);
        clr_a = 1'b1; in_valid_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0; in_valid_a = 1'b0;
        mq.delete();
        chk("clr_sum_abs", sum_abs_a, 0);
        chk("clr_nz_cnt", nz_cnt_a, 0);
        chk("clr_in_ready", in_ready_a, 1);
        @(posedge clk); #1;
        chk("clr_pipeline_flushed", sum_abs_a, 0);
        for (int i = 0; i < 4; i++) send_a(8'd12, 8'd12, 16'd144);
        finish_a("clr_window");

        // Asynchronous reset mid-window
        send_a(8'd200, 8'd100, 16'd19900);
        send_a(8'd200, 8'd100, 16'd19900);
        @(posedge clk); #1;
        chk("rst_mid_pre", sum_abs_a, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_sum_abs", sum_abs_a, 0);
        chk("rst_mid_sum_err", sum_err_a, 0);
        chk("rst_mid_max_abs", max_abs_a, 0);
        chk("rst_mid_nz", nz_cnt_a, 0);
        chk("rst_mid_in_ready", in_ready_a, 1);
        chk("rst_mid_out_valid", out_valid_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mq.delete();
        @(posedge clk); #1;
        send_rand_a(4);
        finish_a("post_rst");

        // WIN_LOG2=10: three full-rate random windows
        cyc = 0; nacc = 0; widx = 0; outs = 0;
        x_b = 8'($urandom); y_b = 8'($urandom); z_b = 16'($urandom);
        in_valid_b = 1'b1;
        while (outs < 3 && cyc < 4000) begin
            acc = in_valid_b && in_ready_b;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (nacc == 0) first_acc[widx] = cyc;
                s.x = x_b; s.y = y_b; s.z = z_b;
                mq.push_back(s);
                nacc++;
                x_b = 8'($urandom); y_b = 8'($urandom);
                z_b = ($urandom_range(0, 3) == 0) ? 16'(x_b) * 16'(y_b) : 16'($urandom);
                if (nacc == 1024) begin
                    calc(e_abs, e_err, e_max, e_nz, e_sq);
                    ex_abs[widx] = e_abs; ex_err[widx] = e_err; ex_max[widx] = e_max;
                    ex_nz[widx] = e_nz; ex_sq[widx] = e_sq;
                    widx++;
                    nacc = 0;
                    if (widx == 3) in_valid_b = 1'b0;
                end
            end
            if (out_valid_b) begin
                chk("win10_sum_abs", sum_abs_b, ex_abs[outs]);
                chk("win10_sum_err", $signed(sum_err_b), ex_err[outs]);
                chk("win10_max_abs", max_abs_b, ex_max[outs]);
                chk("win10_nz_cnt", nz_cnt_b, ex_nz[outs]);
`ifdef ERR_SQ_EN
                chk("win10_sum_sq", sum_sq_b, ex_sq[outs]);
`endif
                outs++;
            end
        end
        chk("win10_results_seen", outs, 3);
        chk("win10_period_1", first_acc[1] - first_acc[0], 1027);
        chk("win10_period_2", first_acc[2] - first_acc[1], 1027);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
